// File: rtl/door_controller.sv
// Elevator door FSM driven by 0.5 s ticks recovered from the 2 Hz divider output.
// Serves open/close requests with obstruction reopen and a sticky car-motion interlock fault.
module door_controller #(
  parameter int OPEN_TICKS = 6,
  parameter int MOVE_TICKS = 2
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic       clk_2Hz,
  input  logic       open_req,
  input  logic       close_btn,
  input  logic       obstruct,
  input  logic       car_moving,
  output logic [1:0] door_state,
  output logic       door_closed,
  output logic       door_fully_open,
  output logic       motor_open,
  output logic       motor_close,
  output logic       door_fault
);

  localparam int MAX_TICKS = (OPEN_TICKS > MOVE_TICKS) ? OPEN_TICKS : MOVE_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);
  localparam logic [CW-1:0] OPEN_LAST = CW'(OPEN_TICKS - 1);
  localparam logic [CW-1:0] MOVE_LAST = CW'(MOVE_TICKS - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

  typedef enum logic [1:0] {
    CLOSED  = 2'b00,
    OPENING = 2'b01,
    OPEN    = 2'b10,
    CLOSING = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic          fault_q, fault_d;
  logic          closed_q, closed_d;
  logic          fully_open_q, fully_open_d;
  logic          mot_open_q, mot_open_d;
  logic          mot_close_q, mot_close_d;
  logic          tick_s;

  // Two-flop synchroniser plus edge-detect flop for the slow clock
  always_comb begin
    s1_d   = clk_2Hz;
    s2_d   = s1_q;
    s3_d   = s2_q;
    tick_s = s2_q & ~s3_q;
  end

  // Next-state, counter, fault and output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = fault_q | (car_moving & (state_q != CLOSED));
    case (state_q)
      CLOSED: begin
        if (open_req && !car_moving) begin
          state_d = OPENING;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q;
        end
      end
      OPENING: begin
        if (tick_s && (cnt_q == MOVE_LAST)) begin
          state_d = OPEN;
          cnt_d   = CNT_ZERO;
        end else if (tick_s) begin
          cnt_d   = cnt_q + CNT_ONE;
        end else begin
          cnt_d   = cnt_q;
        end
      end
      OPEN: begin
        // A hold-open request restarts dwell and overrides both the timer and close_btn
        if (open_req || obstruct) begin
          cnt_d   = CNT_ZERO;
        end else if (close_btn) begin
          state_d = CLOSING;
          cnt_d   = CNT_ZERO;
        end else if (tick_s && (cnt_q == OPEN_LAST)) begin
          state_d = CLOSING;
          cnt_d   = CNT_ZERO;
        end else if (tick_s) begin
          cnt_d   = cnt_q + CNT_ONE;
        end else begin
          cnt_d   = cnt_q;
        end
      end
      CLOSING: begin
        if (obstruct || open_req) begin
          state_d = OPENING;
          cnt_d   = CNT_ZERO;
        end else if (tick_s && (cnt_q == MOVE_LAST)) begin
          state_d = CLOSED;
          cnt_d   = CNT_ZERO;
        end else if (tick_s) begin
          cnt_d   = cnt_q + CNT_ONE;
        end else begin
          cnt_d   = cnt_q;
        end
      end
      default: begin
        state_d = CLOSED;
        cnt_d   = CNT_ZERO;
      end
    endcase
    closed_d     = (state_d == CLOSED);
    fully_open_d = (state_d == OPEN);
    mot_open_d   = (state_d == OPENING);
    mot_close_d  = (state_d == CLOSING);
  end

  // State, counter, synchroniser and registered output flops
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= CLOSED;
      cnt_q        <= CNT_ZERO;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      fault_q      <= 1'b0;
      closed_q     <= 1'b1;
      fully_open_q <= 1'b0;
      mot_open_q   <= 1'b0;
      mot_close_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      fault_q      <= fault_d;
      closed_q     <= closed_d;
      fully_open_q <= fully_open_d;
      mot_open_q   <= mot_open_d;
      mot_close_q  <= mot_close_d;
    end
  end

  assign door_state      = state_q;
  assign door_closed     = closed_q;
  assign door_fully_open = fully_open_q;
  assign motor_open      = mot_open_q;
  assign motor_close     = mot_close_q;
  assign door_fault      = fault_q;

endmodule

// File: tb/tb_door_controller.sv
// Scoreboard bench for door_controller: the driver pushes reference-model expectations,
// a monitor pops and compares them against the DUT outputs every clock.
module tb_door_controller;

  localparam int OPEN_T = 6;
  localparam int MOVE_T = 2;
  localparam int S_CLOSED = 0, S_OPENING = 1, S_OPEN = 2, S_CLOSING = 3;

  logic clk_100MHz = 1'b0;
  logic reset_n    = 1'b0;
  logic clk_2Hz    = 1'b0;
  logic open_req   = 1'b0;
  logic close_btn  = 1'b0;
  logic obstruct   = 1'b0;
  logic car_moving = 1'b0;
  logic [1:0] door_state;
  logic door_closed, door_fully_open, motor_open, motor_close, door_fault;

  door_controller #(.OPEN_TICKS(OPEN_T), .MOVE_TICKS(MOVE_T)) dut (
    .clk_100MHz(clk_100MHz), .reset_n(reset_n), .clk_2Hz(clk_2Hz),
    .open_req(open_req), .close_btn(close_btn), .obstruct(obstruct),
    .car_moving(car_moving), .door_state(door_state), .door_closed(door_closed),
    .door_fully_open(door_fully_open), .motor_open(motor_open),
    .motor_close(motor_close), .door_fault(door_fault)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int n_checks = 0;
  int n_fail   = 0;
  logic [6:0] exp_q[$];
  logic [6:0] mon_act, mon_exp;

  // Reference model: door phase, ticks elapsed in that phase, fault flag, slow-clock history
  int m_state, m_elapsed;
  bit m_fault;
  bit hist[$];
  bit h_o, h_c, h_ob, h_cm;

  function automatic logic [6:0] expect_vec();
    logic [1:0] code;
    code = 2'(m_state);
    return {code, m_state == S_CLOSED, m_state == S_OPEN, m_state == S_OPENING,
            m_state == S_CLOSING, m_fault};
  endfunction

  task automatic model_reset();
    m_state = S_CLOSED;
    m_elapsed = 0;
    m_fault = 1'b0;
    hist = '{1'b0, 1'b0, 1'b0};
  endtask

  // A tick acts on the edge two samples after the first high sample of clk_2Hz
  task automatic model_step(input bit o, input bit c, input bit ob, input bit cm, input bit ck);
    bit tick;
    hist.push_front(ck);
    tick = hist[2] && !hist[3];
    void'(hist.pop_back());
    if (cm && m_state != S_CLOSED) m_fault = 1'b1;
    case (m_state)
      S_CLOSED:  if (o && !cm) begin m_state = S_OPENING; m_elapsed = 0; end
      S_OPENING: if (tick) begin
                   m_elapsed++;
                   if (m_elapsed == MOVE_T) begin m_state = S_OPEN; m_elapsed = 0; end
                 end
      S_OPEN:    if (o || ob) m_elapsed = 0;
                 else if (c) begin m_state = S_CLOSING; m_elapsed = 0; end
                 else if (tick) begin
                   m_elapsed++;
                   if (m_elapsed == OPEN_T) begin m_state = S_CLOSING; m_elapsed = 0; end
                 end
      default:   if (o || ob) begin m_state = S_OPENING; m_elapsed = 0; end
                 else if (tick) begin
                   m_elapsed++;
                   if (m_elapsed == MOVE_T) begin m_state = S_CLOSED; m_elapsed = 0; end
                 end
    endcase
  endtask

  task automatic step(input bit o, input bit c, input bit ob, input bit cm, input bit ck);
    @(negedge clk_100MHz);
    reset_n = 1'b1;
    open_req = o; close_btn = c; obstruct = ob; car_moving = cm; clk_2Hz = ck;
    model_step(o, c, ob, cm, ck);
    exp_q.push_back(expect_vec());
  endtask

  task automatic hold(input int n, input bit ck);
    for (int i = 0; i < n; i++) step(h_o, h_c, h_ob, h_cm, ck);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      hold(4, 1'b1);
      hold(4, 1'b0);
    end
  endtask

  task automatic check_reset_vals(input string name);
    n_checks++;
    if ({door_state, door_closed, door_fully_open, motor_open, motor_close, door_fault} !== 7'b0010000) begin
      n_fail++;
      $display("FAIL %s actual=%b%b%b%b%b%b required=0010000", name, door_state, door_closed,
               door_fully_open, motor_open, motor_close, door_fault);
    end
  endtask

  // Assert reset between clock edges and check outputs before any edge arrives
  task automatic reset_pulse(input int toggles);
    @(posedge clk_100MHz);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    check_reset_vals("async_reset");
    for (int i = 0; i < toggles; i++) begin
      @(negedge clk_100MHz);
      clk_2Hz = ~clk_2Hz;
      @(posedge clk_100MHz);
      #1;
      check_reset_vals("reset_hold");
    end
  endtask

  // Monitor: every clock out of reset the DUT presents outputs that must match the queue head
  initial begin
    forever begin
      @(posedge clk_100MHz);
      #1;
      if (reset_n) begin
        n_checks++;
        mon_act = {door_state, door_closed, door_fully_open, motor_open, motor_close, door_fault};
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_underflow t=%0t actual=%b required=queued_entry", $time, mon_act);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_act !== mon_exp) begin
            n_fail++;
            $display("FAIL outputs t=%0t actual=%b required=%b", $time, mon_act, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    bit ck;
    int half, cnt_ph;
    model_reset();
    h_o = 0; h_c = 0; h_ob = 0; h_cm = 0;
    repeat (3) @(posedge clk_100MHz);
    #1;
    check_reset_vals("power_on_reset");

    // Reset mid-OPENING, slow clock toggling under reset
    step(1, 0, 0, 0, 0);
    reset_pulse(8);

    // Full cycle, then a long-held slow clock counts one tick only
    step(1, 0, 0, 0, 0);
    ticks(12);
    step(1, 0, 0, 0, 0);
    hold(100, 1'b1);
    hold(8, 1'b0);
    ticks(12);

    // Obstruction reopen from CLOSING and hold-open in OPEN
    step(1, 0, 0, 0, 0);
    ticks(8);
    ticks(1);
    step(0, 0, 1, 0, 0);
    ticks(3);
    h_ob = 1; ticks(10); h_ob = 0;
    ticks(12);

    // close_btn alone, with obstruct, and with open_req
    step(1, 0, 0, 0, 0);
    ticks(4);
    step(0, 1, 0, 0, 0);
    ticks(1);
    step(1, 0, 0, 0, 0);
    ticks(4);
    step(0, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    ticks(12);

    // Interlock: ignored request while moving, then fault while open
    h_cm = 1; step(1, 0, 0, 1, 0); hold(4, 1'b0); h_cm = 0;
    step(1, 0, 0, 0, 0);
    ticks(3);
    step(0, 0, 0, 1, 0);
    ticks(12);
    hold(4, 1'b0);
    reset_pulse(2);

    // Tick coincident with obstruct in CLOSING at cnt=1
    step(1, 0, 0, 0, 0);
    ticks(3);
    step(0, 1, 0, 0, 0);
    ticks(1);
    hold(2, 1'b1);
    step(0, 0, 1, 0, 1);
    hold(5, 1'b0);
    ticks(4);

    // Randomized traffic with variable slow-clock phase lengths
    ck = 1'b0; half = 4; cnt_ph = 0;
    for (int i = 0; i < 4000; i++) begin
      if (++cnt_ph >= half) begin
        ck = ~ck; cnt_ph = 0; half = $urandom_range(1, 7);
      end
      if ($urandom_range(0, 599) == 0) reset_pulse(1);
      step($urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 13) == 0, $urandom_range(0, 39) == 0, ck);
    end

    @(posedge clk_100MHz);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
